// File: rtl/seq_pkg.sv
// Shared definitions for the cyclic symbol stream: width, start symbol,
// monitor state encoding and the symbol successor function.
package seq_pkg;

  localparam int unsigned SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t SYM_START = 2'b11;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } state_t;

  // Next symbol in the stream, wrapping 3 -> 0
  function automatic sym_t succ(input sym_t s);
    return s + sym_t'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with an
// increment leaves the count at 1 so the coincident event is not lost.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sequence_lock_monitor.sv
// Lock monitor for the repeating 3,0,1,2 symbol stream: acquires lock after
// a run of correct successors, flywheels through isolated errors, counts them.
module sequence_lock_monitor
  import seq_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             clockPulse,
  input  logic             reset,
  input  logic [SYM_W-1:0] symbolIn,
  input  logic             symbolValid,
  input  logic             clearCount,
  output logic             locked,
  output logic             errorPulse,
  output logic [ERR_W-1:0] errorCount,
  output logic             frameStart,
  output logic [SYM_W-1:0] expectedSym
);

  localparam int unsigned CNT_W = 4;

  state_t           state;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  logic             match_c;
  logic             in_lock_c;
  logic             count_err_c;
  logic [CNT_W-1:0] good_next_c;
  logic [CNT_W-1:0] bad_next_c;

  always_comb begin
    match_c     = (symbolIn == expectedSym);
    in_lock_c   = (state == LOCKED) || (state == SLIP);
    count_err_c = symbolValid && in_lock_c && !match_c;
    good_next_c = good_cnt + CNT_W'(1);
    bad_next_c  = bad_cnt + CNT_W'(1);
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clockPulse),
    .rst   (reset),
    .inc   (count_err_c),
    .clr   (clearCount),
    .count (errorCount)
  );

  // Lock state machine; pulses clear every cycle unless set below
  always_ff @(posedge clockPulse) begin
    if (reset) begin
      state       <= HUNT;
      locked      <= 1'b0;
      errorPulse  <= 1'b0;
      frameStart  <= 1'b0;
      expectedSym <= SYM_START;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      errorPulse <= 1'b0;
      frameStart <= 1'b0;
      if (symbolValid) begin
        unique case (state)
          HUNT: begin
            expectedSym <= succ(symbolIn);
            good_cnt    <= CNT_W'(1);
            state       <= VERIFY;
          end
          VERIFY: begin
            expectedSym <= succ(symbolIn);
            if (match_c) begin
              good_cnt <= good_next_c;
              if (good_next_c == CNT_W'(LOCK_COUNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= CNT_W'(1);
            end
          end
          LOCKED: begin
            expectedSym <= succ(expectedSym);
            if (match_c) begin
              frameStart <= (symbolIn == SYM_START);
            end else begin
              errorPulse <= 1'b1;
              if (UNLOCK_COUNT == 1) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                state   <= SLIP;
                bad_cnt <= CNT_W'(1);
              end
            end
          end
          SLIP: begin
            expectedSym <= succ(expectedSym);
            if (match_c) begin
              frameStart <= (symbolIn == SYM_START);
              bad_cnt    <= '0;
              state      <= LOCKED;
            end else begin
              errorPulse <= 1'b1;
              if (bad_next_c == CNT_W'(UNLOCK_COUNT)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                bad_cnt <= bad_next_c;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_lock_monitor.sv
// Bench for sequence_lock_monitor: three parameterisations driven in parallel,
// directed scenarios followed by random traffic, all checked against a model.
module tb_sequence_lock_monitor;

  logic       clk;
  logic       reset;
  logic [1:0] symbolIn;
  logic       symbolValid;
  logic       clearCount;

  logic       lk [3];
  logic       ep [3];
  logic       fs [3];
  logic [1:0] es [3];
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic [2:0] ec2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Per-instance configuration: lock run, unlock misses, error ceiling
  int lc_cfg [3]   = '{4, 4, 2};
  int uc_cfg [3]   = '{2, 2, 1};
  int emax_cfg [3] = '{255, 3, 7};

  // Model: lock flag plus run / miss lengths rather than named states
  bit m_lock [3];
  int m_run  [3];
  int m_miss [3];
  int m_exp  [3];
  int m_err  [3];
  bit m_ep   [3];
  bit m_fs   [3];

  logic [1:0] g;

  sequence_lock_monitor #(.LOCK_COUNT(4), .UNLOCK_COUNT(2), .ERR_W(8)) dut_a (
    .clockPulse(clk), .reset(reset), .symbolIn(symbolIn), .symbolValid(symbolValid),
    .clearCount(clearCount), .locked(lk[0]), .errorPulse(ep[0]), .errorCount(ec0),
    .frameStart(fs[0]), .expectedSym(es[0]));

  sequence_lock_monitor #(.LOCK_COUNT(4), .UNLOCK_COUNT(2), .ERR_W(2)) dut_b (
    .clockPulse(clk), .reset(reset), .symbolIn(symbolIn), .symbolValid(symbolValid),
    .clearCount(clearCount), .locked(lk[1]), .errorPulse(ep[1]), .errorCount(ec1),
    .frameStart(fs[1]), .expectedSym(es[1]));

  sequence_lock_monitor #(.LOCK_COUNT(2), .UNLOCK_COUNT(1), .ERR_W(3)) dut_c (
    .clockPulse(clk), .reset(reset), .symbolIn(symbolIn), .symbolValid(symbolValid),
    .clearCount(clearCount), .locked(lk[2]), .errorPulse(ep[2]), .errorCount(ec2),
    .frameStart(fs[2]), .expectedSym(es[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input int i, input int s, input bit v, input bit c, input bit r);
    bit hit;
    bit counted;
    if (r) begin
      m_lock[i] = 0; m_run[i] = 0; m_miss[i] = 0; m_exp[i] = 3;
      m_err[i] = 0; m_ep[i] = 0; m_fs[i] = 0;
      return;
    end
    m_ep[i] = 0;
    m_fs[i] = 0;
    counted = 0;
    if (v) begin
      hit = (s == m_exp[i]);
      if (!m_lock[i]) begin
        m_run[i] = (m_run[i] > 0 && hit) ? m_run[i] + 1 : 1;
        m_exp[i] = (s + 1) % 4;
        if (m_run[i] == lc_cfg[i]) m_lock[i] = 1;
      end else begin
        m_exp[i] = (m_exp[i] + 1) % 4;
        if (hit) begin
          m_miss[i] = 0;
          m_fs[i] = (s == 3);
        end else begin
          m_ep[i] = 1;
          counted = 1;
          m_miss[i]++;
          if (m_miss[i] == uc_cfg[i]) begin
            m_lock[i] = 0; m_run[i] = 0; m_miss[i] = 0;
          end
        end
      end
    end
    if (c) m_err[i] = counted ? 1 : 0;
    else if (counted && m_err[i] < emax_cfg[i]) m_err[i]++;
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] cnt [3];
    cnt[0] = 32'(ec0);
    cnt[1] = 32'(ec1);
    cnt[2] = 32'(ec2);
    for (int i = 0; i < 3; i++) begin
      chk("locked",      i, 32'(lk[i]), 32'(m_lock[i]));
      chk("errorPulse",  i, 32'(ep[i]), 32'(m_ep[i]));
      chk("frameStart",  i, 32'(fs[i]), 32'(m_fs[i]));
      chk("expectedSym", i, 32'(es[i]), 32'(m_exp[i]));
      chk("errorCount",  i, cnt[i],     32'(m_err[i]));
    end
  endtask

  // One clock: drive after the falling edge, update model at the rising edge, check 1 time unit later
  task automatic cycle(input logic [1:0] s, input logic v, input logic c, input logic r);
    symbolIn    = s;
    symbolValid = v;
    clearCount  = c;
    reset       = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, int'(s), v, c, r);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic send_good();
    cycle(g, 1'b1, 1'b0, 1'b0);
    g = g + 2'd1;
  endtask

  task automatic send_bad();
    cycle(g + 2'd2, 1'b1, 1'b0, 1'b0);
    g = g + 2'd1;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) cycle(2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(2'd0, 1'b0, 1'b0, 1'b1);
    g = 2'd3;
  endtask

  initial begin
    reset = 1'b1; symbolValid = 1'b0; clearCount = 1'b0; symbolIn = 2'd0;
    g = 2'd3;
    do_reset();
    do_reset();

    // Acquire and hold lock over three frames
    for (int k = 0; k < 12; k++) send_good();

    // Single-symbol slip: 1 where 0 is expected
    while (g != 2'd0) send_good();
    cycle(2'd1, 1'b1, 1'b0, 1'b0);
    g = g + 2'd1;
    for (int k = 0; k < 8; k++) send_good();

    // Loss of lock with 0,0,0 then recovery
    while (g != 2'd2) send_good();
    for (int k = 0; k < 3; k++) cycle(2'd0, 1'b1, 1'b0, 1'b0);
    g = 2'd1;
    for (int k = 0; k < 8; k++) send_good();

    // Validity gaps around a VERIFY reseed
    do_reset();
    cycle(2'd3, 1'b1, 1'b0, 1'b0); gap(3);
    cycle(2'd0, 1'b1, 1'b0, 1'b0); gap(3);
    cycle(2'd2, 1'b1, 1'b0, 1'b0); gap(3);
    cycle(2'd3, 1'b1, 1'b0, 1'b0); gap(3);
    cycle(2'd0, 1'b1, 1'b0, 1'b0); gap(3);
    cycle(2'd1, 1'b1, 1'b0, 1'b0); gap(3);
    g = 2'd2;
    for (int k = 0; k < 4; k++) send_good();

    // Saturation, then clear coincident with an error
    do_reset();
    for (int k = 0; k < 6; k++) send_good();
    for (int k = 0; k < 5; k++) begin
      send_bad();
      send_good();
    end
    cycle(g + 2'd2, 1'b1, 1'b1, 1'b0);
    g = g + 2'd1;
    for (int k = 0; k < 3; k++) send_good();
    cycle(g, 1'b1, 1'b1, 1'b0);
    g = g + 2'd1;

    // Reset while in SLIP with a valid symbol present
    for (int k = 0; k < 6; k++) send_good();
    send_bad();
    cycle(g, 1'b1, 1'b0, 1'b1);
    g = 2'd3;
    for (int k = 0; k < 6; k++) send_good();

    // Random traffic: gaps, sporadic bad symbols, clears and resets
    for (int k = 0; k < 4000; k++) begin
      logic       v;
      logic       c;
      logic       r;
      logic [1:0] s;
      r = ($urandom_range(0, 999) < 4);
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : g;
      cycle(s, v, c, r);
      if (r) g = 2'd3;
      else if (v) g = g + 2'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
